// File: rtl/crf_pkg.sv
// Shared constants and types for the sample datapath. The packer and the
// feature-select mux both use these so the lane mapping is defined once.
package crf_pkg;

  localparam int unsigned FEAT_W   = 16;
  localparam int unsigned NUM_FEAT = 16;
  localparam int unsigned IDX_W    = $clog2(NUM_FEAT);
  localparam int unsigned SAMPLE_W = FEAT_W * NUM_FEAT;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

  typedef logic [FEAT_W-1:0]   feat_t;
  typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sample_packer.sv
// Packs a stream of features into full samples (lane k = feature k) and holds
// each completed sample behind a valid/ready handshake while the next one fills.
module sample_packer
  import crf_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             feat_valid,
  input  feat_t            feat_data,
  output logic             feat_ready,
  input  logic             abort,
  output logic [IDX_W-1:0] fill_cnt,
  output logic             sample_valid,
  output sample_t          sample_data,
  input  logic             sample_ready
);

  logic [IDX_W-1:0] fill_q, fill_d;
  sample_t          asm_q, asm_d;
  sample_t          data_q, data_d;
  logic             valid_q, valid_d;
  logic             last, accept, drain, complete;

  always_comb begin
    last     = (fill_q == LAST_IDX);
    // Only the completing feature ever waits for the output register to free up.
    feat_ready = !abort && (!last || !valid_q || sample_ready);
    accept   = feat_valid && feat_ready;
    drain    = valid_q && sample_ready;
    complete = accept && last;

    asm_d   = asm_q;
    fill_d  = fill_q;
    data_d  = data_q;
    valid_d = valid_q;

    if (accept) begin
      asm_d[int'(fill_q) * FEAT_W +: FEAT_W] = feat_data;
      fill_d = last ? '0 : fill_q + 1'b1;
    end
    if (abort) begin
      fill_d = '0;
    end

    // asm_d already carries the last lane, so the full sample moves in one edge.
    if (complete) begin
      data_d  = asm_d;
      valid_d = 1'b1;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q  <= '0;
      asm_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      fill_q  <= fill_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign fill_cnt     = fill_q;
  assign sample_valid = valid_q;
  assign sample_data  = data_q;

endmodule

// File: tb/tb_sample_packer.sv
// Directed and randomized checks of sample_packer against hand-computed
// samples and an independent handshake/lane model.
module tb_sample_packer;
  import crf_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             feat_valid;
  feat_t            feat_data;
  logic             feat_ready;
  logic             abort;
  logic [IDX_W-1:0] fill_cnt;
  logic             sample_valid;
  sample_t          sample_data;
  logic             sample_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sample_packer dut (
    .clk          (clk),
    .rst          (rst),
    .feat_valid   (feat_valid),
    .feat_data    (feat_data),
    .feat_ready   (feat_ready),
    .abort        (abort),
    .fill_cnt     (fill_cnt),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready)
  );

  task automatic check(input string tag, input logic [SAMPLE_W-1:0] got,
                       input logic [SAMPLE_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int v);
    feat_valid = 1'b1;
    feat_data  = FEAT_W'(v);
    tick();
    feat_valid = 1'b0;
  endtask

  function automatic sample_t ramp(input int base);
    sample_t s;
    s = '0;
    for (int k = 0; k < NUM_FEAT; k++) begin
      s[k * FEAT_W +: FEAT_W] = FEAT_W'(base + k);
    end
    return s;
  endfunction

  sample_t    masm;
  sample_t    exp_q[$];
  int         mfill;
  int         nout;
  int         ncyc;
  logic       mready;

  initial begin
    rst          = 1'b1;
    feat_valid   = 1'b0;
    feat_data    = '0;
    abort        = 1'b0;
    sample_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_fill", fill_cnt, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_data", sample_data, 0);
    check("rst_ready", feat_ready, 1);

    // Basic fill with consumer ready.
    sample_ready = 1'b1;
    for (int k = 0; k < NUM_FEAT; k++) begin
      feed(16'h1000 + k);
      if (k == NUM_FEAT - 2) check("t1_not_yet", sample_valid, 0);
    end
    check("t1_valid", sample_valid, 1);
    check("t1_data", sample_data, ramp(16'h1000));
    check("t1_fill", fill_cnt, 0);
    tick();
    check("t1_drop", sample_valid, 0);

    // Backpressure: second sample stalls on its last feature.
    sample_ready = 1'b0;
    for (int k = 0; k < NUM_FEAT; k++) feed(16'h2000 + k);
    check("t2_valid", sample_valid, 1);
    check("t2_data", sample_data, ramp(16'h2000));
    for (int k = 0; k < NUM_FEAT - 1; k++) feed(16'h3000 + k);
    check("t2_fill15", fill_cnt, 15);
    feat_valid = 1'b1;
    feat_data  = 16'h300F;
    #1;
    check("t2_stall_ready", feat_ready, 0);
    tick();
    check("t2_stall_fill", fill_cnt, 15);
    check("t2_held_data", sample_data, ramp(16'h2000));
    sample_ready = 1'b1;
    #1;
    check("t2_release_ready", feat_ready, 1);
    tick();
    feat_valid   = 1'b0;
    sample_ready = 1'b0;
    check("t2_nobubble", sample_valid, 1);
    check("t2_data2", sample_data, ramp(16'h3000));
    check("t2_fill0", fill_cnt, 0);
    sample_ready = 1'b1;
    tick();
    check("t2_drain", sample_valid, 0);

    // Continuous streaming: one-cycle valid pulses every 16 cycles.
    feat_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      feat_data = FEAT_W'(16'h4000 + i);
      tick();
      check("t3_valid", sample_valid, (i % NUM_FEAT) == NUM_FEAT - 1);
      if ((i % NUM_FEAT) == NUM_FEAT - 1)
        check("t3_data", sample_data, ramp(16'h4000 + i - (NUM_FEAT - 1)));
    end
    feat_valid = 1'b0;
    tick();
    check("t3_end", sample_valid, 0);

    // Abort mid-fill with a held sample present.
    sample_ready = 1'b0;
    for (int k = 0; k < NUM_FEAT; k++) feed(16'h5000 + k);
    for (int k = 0; k < 7; k++) feed(16'h6000 + k);
    check("t4_fill7", fill_cnt, 7);
    abort      = 1'b1;
    feat_valid = 1'b1;
    feat_data  = 16'hDEAD;
    #1;
    check("t4_abort_ready", feat_ready, 0);
    tick();
    abort      = 1'b0;
    feat_valid = 1'b0;
    check("t4_fill0", fill_cnt, 0);
    check("t4_held_valid", sample_valid, 1);
    check("t4_held_data", sample_data, ramp(16'h5000));
    sample_ready = 1'b1;
    tick();
    check("t4_drain", sample_valid, 0);
    for (int k = 0; k < NUM_FEAT; k++) feed(16'h7000 + k);
    check("t4_post_valid", sample_valid, 1);
    check("t4_post_data", sample_data, ramp(16'h7000));
    tick();

    // Reset mid-fill while a sample is held.
    sample_ready = 1'b0;
    for (int k = 0; k < NUM_FEAT; k++) feed(16'h8000 + k);
    for (int k = 0; k < 9; k++) feed(16'h9000 + k);
    check("t5_fill9", fill_cnt, 9);
    check("t5_valid", sample_valid, 1);
    rst          = 1'b1;
    feat_valid   = 1'b1;
    feat_data    = 16'hBEEF;
    sample_ready = 1'b1;
    tick();
    rst          = 1'b0;
    feat_valid   = 1'b0;
    sample_ready = 1'b0;
    check("t5_fill", fill_cnt, 0);
    check("t5_valid0", sample_valid, 0);
    check("t5_data0", sample_data, 0);

    // Randomized handshakes against a lane/queue model.
    masm  = '0;
    mfill = 0;
    nout  = 0;
    ncyc  = 0;
    while (nout < 200 && ncyc < 40000) begin
      feat_valid   = 1'($urandom_range(0, 1));
      feat_data    = FEAT_W'($urandom);
      sample_ready = 1'($urandom_range(0, 1));
      #1;
      mready = (mfill != NUM_FEAT - 1) || (exp_q.size() == 0) || sample_ready;
      check("rnd_ready", feat_ready, mready);
      check("rnd_valid", sample_valid, exp_q.size() != 0);
      check("rnd_fill", fill_cnt, mfill);
      if (exp_q.size() != 0 && sample_ready) begin
        check("rnd_data", sample_data, exp_q.pop_front());
        nout++;
      end
      if (feat_valid && mready) begin
        masm[mfill * FEAT_W +: FEAT_W] = feat_data;
        if (mfill == NUM_FEAT - 1) begin
          exp_q.push_back(masm);
          mfill = 0;
        end else begin
          mfill++;
        end
      end
      tick();
      ncyc++;
    end
    if (nout < 200) check("rnd_timeout", nout, 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
